// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose:
//   Shares one single-port, synchronous-read instruction memory (1-cycle read
//   latency) between two requesters: port 0 (CPU instruction fetch) and
//   port 1 (debug/loader readback). One read is issued per cycle. The read
//   data is routed back to whichever port owns the outstanding read, and
//   backpressure is applied while that response has not been consumed. The
//   memory address is held during a stall, so the registered read data stays
//   valid.
//
// Configuration macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin arbitration. A 1-bit pointer
//                                gives priority to the port that was not
//                                granted last. It moves only on a handshake.
//                   undefined -> fixed priority. Port 0 always wins, and there
//                                is no pointer register.
//
// Ports:
//   clk_i          in   1       clock, all state updates on posedge
//   rst_ni         in   1       asynchronous active-low reset
//   req_valid_i    in   2       per-port read request valid ([0]=fetch, [1]=debug)
//   req_addr0_i    in   ADDR_W  port 0 byte address
//   req_addr1_i    in   ADDR_W  port 1 byte address
//   req_ready_o    out  2       per-port request accepted this cycle (one-hot/zero)
//   resp_valid_o   out  2       per-port read data valid (one-hot/zero)
//   resp_ready_i   in   2       per-port response consumed
//   resp_data_o    out  DATA_W  shared read data, qualified by resp_valid_o
//   mem_addr_o     out  ADDR_W  memory address (registered by the memory)
//   mem_rd_data_i  in   DATA_W  memory read data, one cycle after mem_addr_o
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_valid_i,
  input  logic [ADDR_W-1:0] req_addr0_i,
  input  logic [ADDR_W-1:0] req_addr1_i,
  output logic [1:0]        req_ready_o,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic              grant_ok;
  logic              grant;
  logic              winner;
  logic [ADDR_W-1:0] win_addr;

`ifdef IMEM_ARB_RR_EN
  logic prio_q, prio_d;
`endif

  // A new read may be issued when nothing is outstanding, or when the
  // outstanding response is consumed in this same cycle (drain + issue).
  // Reset gates the grant so that req_ready_o and mem_addr_o read 0 while
  // rst_ni is low, even if requests are still asserted.
  assign grant_ok = rst_ni && ((state_q == IDLE) || resp_ready_i[port_q]);
  assign grant    = grant_ok && (|req_valid_i);

  // The winner is only meaningful when at least one port is requesting.
  always_comb begin
`ifdef IMEM_ARB_RR_EN
    if (&req_valid_i) begin
      winner = prio_q;
    end else begin
      winner = ~req_valid_i[0];
    end
`else
    winner = ~req_valid_i[0];
`endif
    win_addr = winner ? req_addr1_i : req_addr0_i;
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    addr_hold_d  = addr_hold_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_data_o  = '0;
    mem_addr_o   = addr_hold_q;
`ifdef IMEM_ARB_RR_EN
    prio_d       = prio_q;
`endif

    // Read data passes straight through from the memory. During a stall the
    // address is held, so the data stays stable without an extra register.
    if (state_q == PEND) begin
      resp_valid_o[port_q] = 1'b1;
      resp_data_o          = mem_rd_data_i;
      if (resp_ready_i[port_q]) begin
        state_d = IDLE;
      end
    end

    if (grant) begin
      req_ready_o[winner] = 1'b1;
      mem_addr_o          = win_addr;
      addr_hold_d         = win_addr;
      port_d              = winner;
      state_d             = PEND;
`ifdef IMEM_ARB_RR_EN
      prio_d              = ~winner;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      addr_hold_q <= '0;
`ifdef IMEM_ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      addr_hold_q <= addr_hold_d;
`ifdef IMEM_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Purpose:
//   Self-checking bench for imem_arbiter. A behavioural memory returns
//   0xC0DE0000 | word_index, one cycle after it samples mem_addr_o. A
//   transaction-level model tracks the outstanding read in a queue and
//   predicts every output on every cycle. Directed sequences pin down the
//   model with literal expectations. These are followed by randomized
//   traffic, which includes occasional asynchronous resets.
//   The arbitration mode follows IMEM_ARB_RR_EN, as it does in the design.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i;
  logic              rst_ni;
  logic [1:0]        req_valid_i;
  logic [ADDR_W-1:0] req_addr0_i;
  logic [ADDR_W-1:0] req_addr1_i;
  logic [1:0]        req_ready_o;
  logic [1:0]        resp_valid_o;
  logic [1:0]        resp_ready_i;
  logic [DATA_W-1:0] resp_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i;

  int compared   = 0;
  int mismatched = 0;
  logic checkEn  = 1'b0;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_addr0_i   (req_addr0_i),
    .req_addr1_i   (req_addr1_i),
    .req_ready_o   (req_ready_o),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_data_o   (resp_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 | {22'd0, a[11:2]};
  endfunction

  // Synchronous-read memory: data appears the cycle after the address is sampled.
  always @(posedge clk_i) mem_rd_data_i <= memWord(mem_addr_o);

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        port;
    logic [31:0] addr;
  } txn_t;

  txn_t        outQ[$];
  logic [31:0] holdAddr  = 32'd0;
  logic        lastGrant = 1'b1;

  task automatic computeExp(output logic [1:0] eReqReady, output logic [31:0] eMemAddr,
                            output logic [1:0] eRespValid, output logic [31:0] eRespData,
                            output logic gnt, output logic g, output logic [31:0] gAddr);
    logic busy;
    logic allowed;
    busy    = (outQ.size() != 0);
    allowed = rst_ni && (!busy || resp_ready_i[outQ[0].port]);
    gnt     = allowed && (req_valid_i != 2'b00);
`ifdef IMEM_ARB_RR_EN
    if (req_valid_i == 2'b11) g = ~lastGrant;
    else                      g = ~req_valid_i[0];
`else
    g = ~req_valid_i[0];
`endif
    gAddr      = g ? req_addr1_i : req_addr0_i;
    eReqReady  = gnt ? (g ? 2'b10 : 2'b01) : 2'b00;
    eMemAddr   = gnt ? gAddr : holdAddr;
    eRespValid = busy ? (outQ[0].port ? 2'b10 : 2'b01) : 2'b00;
    eRespData  = busy ? memWord(outQ[0].addr) : 32'd0;
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    logic [1:0]  eRr, eRv;
    logic [31:0] eMa, eRd, gA;
    logic        gnt, g;
    if (!rst_ni) begin
      outQ.delete();
      holdAddr  <= 32'd0;
      lastGrant <= 1'b1;
    end else begin
      computeExp(eRr, eMa, eRv, eRd, gnt, g, gA);
      if (outQ.size() != 0 && resp_ready_i[outQ[0].port]) void'(outQ.pop_front());
      if (gnt) begin
        outQ.push_back('{port: g, addr: gA});
        holdAddr  <= gA;
        lastGrant <= g;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Every cycle, compare all outputs against the model away from the clock edge.
  always @(negedge clk_i) begin
    logic [1:0]  eRr, eRv;
    logic [31:0] eMa, eRd, gA;
    logic        gnt, g;
    if (checkEn) begin
      computeExp(eRr, eMa, eRv, eRd, gnt, g, gA);
      checkOutput("model req_ready",  {30'd0, req_ready_o},  {30'd0, eRr});
      checkOutput("model mem_addr",   mem_addr_o,            eMa);
      checkOutput("model resp_valid", {30'd0, resp_valid_o}, {30'd0, eRv});
      checkOutput("model resp_data",  resp_data_o,           eRd);
    end
  end

  task automatic applyStimulus(input logic [1:0] rv, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [1:0] rr);
    @(posedge clk_i);
    #1;
    req_valid_i  = rv;
    req_addr0_i  = a0;
    req_addr1_i  = a1;
    resp_ready_i = rr;
    #2;
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = 2'b11;
    req_addr0_i  = 32'h44;
    req_addr1_i  = 32'h48;
    resp_ready_i = 2'b11;
    @(posedge clk_i);
    #3;
    checkEn = 1'b1;
    checkOutput("reset req_ready", {30'd0, req_ready_o}, 32'd0);
    checkOutput("reset mem_addr", mem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;

    // Both ports request continuously.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 32'h100 + 32'(k * 4), 32'h200 + 32'(k * 4), 2'b11);
`ifdef IMEM_ARB_RR_EN
      checkOutput("rr grant", {30'd0, req_ready_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0)
        checkOutput("rr resp_valid", {30'd0, resp_valid_o}, (k % 2 == 0) ? 32'd2 : 32'd1);
`else
      checkOutput("fixed grant", {30'd0, req_ready_o}, 32'd1);
`endif
    end
    applyStimulus(2'b10, 32'h0, 32'h300, 2'b11);
    checkOutput("port1 when port0 idle", {30'd0, req_ready_o}, 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);

    // Port 0 only streams words 0, 1 and 2.
    applyStimulus(2'b01, 32'h0, 32'h0, 2'b01);
    checkOutput("stream grant0", {30'd0, req_ready_o}, 32'd1);
    applyStimulus(2'b01, 32'h4, 32'h0, 2'b01);
    checkOutput("stream grant1", {30'd0, req_ready_o}, 32'd1);
    checkOutput("stream data0", resp_data_o, 32'hC0DE_0000);
    applyStimulus(2'b01, 32'h8, 32'h0, 2'b01);
    checkOutput("stream data1", resp_data_o, 32'hC0DE_0001);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b01);
    checkOutput("stream data2", resp_data_o, 32'hC0DE_0002);
    checkOutput("stream resp_valid", {30'd0, resp_valid_o}, 32'd1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);

    // A stall holds the address and the data.
    applyStimulus(2'b01, 32'h10, 32'h0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 32'h44, 32'h48, 2'b00);
      checkOutput("stall mem_addr", mem_addr_o, 32'h10);
      checkOutput("stall resp_data", resp_data_o, 32'hC0DE_0004);
      checkOutput("stall req_ready", {30'd0, req_ready_o}, 32'd0);
    end
    applyStimulus(2'b11, 32'h44, 32'h48, 2'b01);
`ifdef IMEM_ARB_RR_EN
    checkOutput("stall release grant", {30'd0, req_ready_o}, 32'd2);
`else
    checkOutput("stall release grant", {30'd0, req_ready_o}, 32'd1);
`endif
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);

    // Drain the port 1 read and issue a port 0 read in the same cycle.
    applyStimulus(2'b10, 32'h0, 32'h30, 2'b11);
    applyStimulus(2'b01, 32'h20, 32'h0, 2'b10);
    checkOutput("drain+issue grant", {30'd0, req_ready_o}, 32'd1);
    checkOutput("drain+issue old resp", {30'd0, resp_valid_o}, 32'd2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);
    checkOutput("drain+issue resp_valid", {30'd0, resp_valid_o}, 32'd1);
    checkOutput("drain+issue data", resp_data_o, 32'hC0DE_0008);

    // Assert reset while a read is pending.
    applyStimulus(2'b01, 32'h14, 32'h0, 2'b00);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("pre-reset resp_valid", {30'd0, resp_valid_o}, 32'd1);
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    #1;
    checkOutput("midpend reset req_ready", {30'd0, req_ready_o}, 32'd0);
    checkOutput("midpend reset resp_valid", {30'd0, resp_valid_o}, 32'd0);
    checkOutput("midpend reset resp_data", resp_data_o, 32'd0);
    checkOutput("midpend reset mem_addr", mem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;
    #2;
    checkOutput("post-reset resp_valid", {30'd0, resp_valid_o}, 32'd0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);
    checkOutput("post-reset resp_valid 2", {30'd0, resp_valid_o}, 32'd0);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_i);
      #1;
      rst_ni          = ($urandom_range(0, 199) != 0);
      req_valid_i     = 2'($urandom_range(0, 3));
      req_addr0_i     = $urandom & 32'h0000_0FFF;
      req_addr1_i     = $urandom & 32'h0000_0FFF;
      resp_ready_i[0] = ($urandom_range(0, 9) < 7);
      resp_ready_i[1] = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
